// File: rtl/z_rca_arbiter_if.sv
// Bundle between the operand sources, the round-robin arbiter and the shared
// ripple-carry adder. The arbiter uses the slave view; the environment uses master.
interface z_rca_arbiter_if #(
  parameter int n = 4
);
  logic         req0, req1;
  logic [n-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic [n-1:0] add_a, add_b;
  logic         add_cin;
  logic [n-1:0] add_sum;
  logic         add_cout;
  logic [n-1:0] sum_out;
  logic         cout_out;
  logic         done0, done1;
  logic         gnt;
  logic         busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    output add_a, add_b, add_cin, sum_out, cout_out, done0, done1, gnt, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    input  add_a, add_b, add_cin, sum_out, cout_out, done0, done1, gnt, busy
  );
endinterface

// File: rtl/z_rca_arbiter.sv
// Round-robin sharing controller for one ripple-carry adder: latches the winner's
// operands, waits SETTLE cycles for the ripple to settle, then captures the result.
//
// state | meaning
// IDLE  | waiting for a request; adder inputs and results held
// DRIVE | operands held on the adder while the settle counter runs down
// DONE  | one-cycle done pulse to the granted requester
module z_rca_arbiter #(
  parameter int n      = 4,
  parameter int SETTLE = 2
) (
  input logic             clk,
  input logic             rst,
  z_rca_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         gnt_q, gnt_d;
  logic [n-1:0] a_q, a_d, b_q, b_d;
  logic         cin_q, cin_d;
  logic [n-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         done0_q, done0_d, done1_q, done1_d;
  logic         win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    win     = gnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins.
          win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          a_d     = win ? bus.a1   : bus.a0;
          b_d     = win ? bus.b1   : bus.b0;
          cin_d   = win ? bus.cin1 : bus.cin0;
          gnt_d   = win;
          last_d  = win;
          cnt_d   = LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          sum_d   = bus.add_sum;
          cout_d  = bus.add_cout;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.add_a    = a_q;
  assign bus.add_b    = b_q;
  assign bus.add_cin  = cin_q;
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_z_rca_arbiter.sv
// Scoreboard bench for z_rca_arbiter: three instances (SETTLE = 2, 1, 5), each
// with a behavioural adder; done pulses are checked against queued expectations.
module tb_z_rca_arbiter;
  logic clk = 1'b0;
  logic rst2, rstx;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       idx;
    logic [3:0] sum;
    logic       cout;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  exp_t q5[$];

  z_rca_arbiter_if #(.n(4)) bus2 ();
  z_rca_arbiter_if #(.n(4)) bus1 ();
  z_rca_arbiter_if #(.n(4)) bus5 ();

  assign {bus2.add_cout, bus2.add_sum} = {1'b0, bus2.add_a} + {1'b0, bus2.add_b} + {4'b0, bus2.add_cin};
  assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'b0, bus1.add_cin};
  assign {bus5.add_cout, bus5.add_sum} = {1'b0, bus5.add_a} + {1'b0, bus5.add_b} + {4'b0, bus5.add_cin};

  z_rca_arbiter #(.n(4), .SETTLE(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
  z_rca_arbiter #(.n(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rstx), .bus(bus1));
  z_rca_arbiter #(.n(4), .SETTLE(5)) dut5 (.clk(clk), .rst(rstx), .bus(bus5));

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_done(input string tag, input exp_t e, input int c, input logic d0,
                          input logic d1, input logic g, input logic [3:0] s, input logic co);
    chk({tag, " done cycle"}, c, e.cyc);
    chk({tag, " done onehot"}, int'({d1, d0}), e.idx ? 2 : 1);
    chk({tag, " gnt"}, int'(g), int'(e.idx));
    chk({tag, " sum_out"}, int'(s), int'(e.sum));
    chk({tag, " cout_out"}, int'(co), int'(e.cout));
  endtask

  always @(negedge clk) begin
    if (bus2.done0 || bus2.done1) begin
      if (q2.size() == 0) chk("s2 unexpected done", 1, 0);
      else chk_done("s2", q2.pop_front(), cyc, bus2.done0, bus2.done1, bus2.gnt, bus2.sum_out, bus2.cout_out);
    end
  end

  always @(negedge clk) begin
    if (bus1.done0 || bus1.done1) begin
      if (q1.size() == 0) chk("s1 unexpected done", 1, 0);
      else chk_done("s1", q1.pop_front(), cyc, bus1.done0, bus1.done1, bus1.gnt, bus1.sum_out, bus1.cout_out);
    end
  end

  always @(negedge clk) begin
    if (bus5.done0 || bus5.done1) begin
      if (q5.size() == 0) chk("s5 unexpected done", 1, 0);
      else chk_done("s5", q5.pop_front(), cyc, bus5.done0, bus5.done1, bus5.gnt, bus5.sum_out, bus5.cout_out);
    end
  end

  // Hand-computed vectors: a, b, cin -> sum, cout.
  logic [3:0] va[6]  = '{4'hF, 4'hF, 4'h0, 4'h8, 4'h5, 4'h2};
  logic [3:0] vb[6]  = '{4'h1, 4'hF, 4'h0, 4'h7, 4'hA, 4'h3};
  logic       vc[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] vs[6]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h6};
  logic       vco[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int         t;
    logic [3:0] ra, rb, es;
    logic       rc, ec, sel;
    logic [4:0] s;

    rst2 = 1'b1;
    rstx = 1'b1;
    bus2.req0 = 1'b1; bus2.req1 = 1'b0;
    bus2.a0 = 4'h7; bus2.b0 = 4'h9; bus2.cin0 = 1'b0;
    bus2.a1 = 4'h0; bus2.b1 = 4'h0; bus2.cin1 = 1'b0;
    bus1.req0 = 1'b0; bus1.req1 = 1'b0;
    bus1.a0 = 4'h0; bus1.b0 = 4'h0; bus1.cin0 = 1'b0;
    bus1.a1 = 4'h0; bus1.b1 = 4'h0; bus1.cin1 = 1'b0;
    bus5.req0 = 1'b0; bus5.req1 = 1'b0;
    bus5.a0 = 4'h0; bus5.b0 = 4'h0; bus5.cin0 = 1'b0;
    bus5.a1 = 4'h0; bus5.b1 = 4'h0; bus5.cin1 = 1'b0;

    // Reset held two cycles with req0 high.
    repeat (2) @(negedge clk);
    chk("rst busy", int'(bus2.busy), 0);
    chk("rst add_a", int'(bus2.add_a), 0);
    chk("rst add_b", int'(bus2.add_b), 0);
    chk("rst add_cin", int'(bus2.add_cin), 0);
    chk("rst sum_out", int'(bus2.sum_out), 0);
    chk("rst cout_out", int'(bus2.cout_out), 0);
    chk("rst gnt", int'(bus2.gnt), 0);
    chk("rst done", int'({bus2.done1, bus2.done0}), 0);

    // Single op 7 + 9 + 0 -> sum 0, cout 1.
    rst2 = 1'b0;
    t = cyc;
    q2.push_back(exp_t'{t + 3, 1'b0, 4'h0, 1'b1});
    @(negedge clk);
    chk("single busy", int'(bus2.busy), 1);
    chk("single add_a", int'(bus2.add_a), 7);
    chk("single add_b", int'(bus2.add_b), 9);
    chk("single add_cin", int'(bus2.add_cin), 0);
    bus2.req0 = 1'b0;
    @(negedge clk);
    chk("single add_a held", int'(bus2.add_a), 7);
    repeat (2) @(negedge clk);
    chk("single idle busy", int'(bus2.busy), 0);
    repeat (2) @(negedge clk);
    chk("idle hold sum_out", int'(bus2.sum_out), 0);
    chk("idle hold cout_out", int'(bus2.cout_out), 1);
    chk("idle hold add_a", int'(bus2.add_a), 7);

    // Tie fairness from reset: order 0,1,0,1, done pulses 4 cycles apart.
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    bus2.a1 = 4'h3; bus2.b1 = 4'h4; bus2.cin1 = 1'b1;
    bus2.req0 = 1'b1; bus2.req1 = 1'b1;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      sel = (k % 2) == 1;
      q2.push_back(exp_t'{t + 3 + 4 * k, sel, sel ? 4'h8 : 4'h0, sel ? 1'b0 : 1'b1});
    end
    @(negedge clk);
    chk("tie first gnt", int'(bus2.gnt), 0);
    repeat (4) @(negedge clk);
    chk("tie second gnt", int'(bus2.gnt), 1);
    chk("tie second add_a", int'(bus2.add_a), 3);
    repeat (8) @(negedge clk);
    bus2.req0 = 1'b0; bus2.req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("tie end busy", int'(bus2.busy), 0);

    // Late arrival: req1 rises during requester 0's DRIVE; req0 drops meanwhile.
    bus2.a0 = 4'h5; bus2.b0 = 4'h6; bus2.cin0 = 1'b1;
    bus2.req0 = 1'b1;
    t = cyc;
    q2.push_back(exp_t'{t + 3, 1'b0, 4'hC, 1'b0});
    @(negedge clk);
    bus2.req0 = 1'b0;
    bus2.req1 = 1'b1;
    q2.push_back(exp_t'{t + 7, 1'b1, 4'h8, 1'b0});
    chk("late busy", int'(bus2.busy), 1);
    chk("late gnt0", int'(bus2.gnt), 0);
    repeat (3) @(negedge clk);
    chk("late idle gap", int'(bus2.busy), 0);
    chk("late sum after r0", int'(bus2.sum_out), 12);
    @(negedge clk);
    chk("late gnt1", int'(bus2.gnt), 1);
    bus2.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Abort: reset in the second DRIVE cycle.
    bus2.a0 = 4'hA; bus2.b0 = 4'h3; bus2.cin0 = 1'b0;
    bus2.req0 = 1'b1;
    @(negedge clk);
    bus2.req0 = 1'b0;
    chk("abort drive busy", int'(bus2.busy), 1);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(bus2.busy), 0);
    chk("abort sum_out", int'(bus2.sum_out), 0);
    chk("abort cout_out", int'(bus2.cout_out), 0);
    chk("abort add_a", int'(bus2.add_a), 0);
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort sum held", int'(bus2.sum_out), 0);
    bus2.req1 = 1'b1;
    t = cyc;
    q2.push_back(exp_t'{t + 3, 1'b1, 4'h8, 1'b0});
    @(negedge clk);
    bus2.req1 = 1'b0;
    chk("fresh gnt", int'(bus2.gnt), 1);
    repeat (3) @(negedge clk);

    // SETTLE=1 and SETTLE=5: directed then random operands, alternating requesters.
    rstx = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        ra = va[k]; rb = vb[k]; rc = vc[k]; es = vs[k]; ec = vco[k];
      end else begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rc = 1'($urandom_range(0, 1));
        s  = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
        es = s[3:0];
        ec = s[4];
      end
      sel = (k % 2) == 1;
      t = cyc;
      if (sel) begin
        bus1.a1 = ra; bus1.b1 = rb; bus1.cin1 = rc; bus1.req1 = 1'b1;
        bus5.a1 = ra; bus5.b1 = rb; bus5.cin1 = rc; bus5.req1 = 1'b1;
      end else begin
        bus1.a0 = ra; bus1.b0 = rb; bus1.cin0 = rc; bus1.req0 = 1'b1;
        bus5.a0 = ra; bus5.b0 = rb; bus5.cin0 = rc; bus5.req0 = 1'b1;
      end
      q1.push_back(exp_t'{t + 2, sel, es, ec});
      q5.push_back(exp_t'{t + 6, sel, es, ec});
      @(negedge clk);
      bus1.req0 = 1'b0; bus1.req1 = 1'b0;
      bus5.req0 = 1'b0; bus5.req1 = 1'b0;
      repeat (6) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("s2 queue drained", q2.size(), 0);
    chk("s1 queue drained", q1.size(), 0);
    chk("s5 queue drained", q5.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/z_rca_arbiter.md
# z_rca_arbiter

Sequencing and sharing controller for one `z_n_rca` ripple-carry adder instance. Two requesters compete for the adder. The block arbitrates round-robin, latches the winner's operands onto the adder inputs, and holds them for a programmable number of settle cycles to cover the adder's gate-level ripple delay. It then captures sum and carry into result registers and returns them to the winner with a one-cycle done pulse. It sits between the operand sources and the adder, and is the only driver of the adder inputs.

## Interface
- `n`, 4: operand width; must match the adder's `n`.
- `SETTLE`, 2: cycles the adder inputs are held stable before capture; legal range 1..255.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1 each: level request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1` input n each: operands of requester 0 / 1; must be valid while the corresponding req is high.
- `cin0`, `cin1` input 1 each: carry-in of requester 0 / 1.
- `add_a`, `add_b` output n: registered operands driven to the adder.
- `add_cin` output 1: registered carry-in driven to the adder.
- `add_sum` input n, `add_cout` input 1: adder results.
- `sum_out` output n, `cout_out` output 1: registered captured result, held until the next capture.
- `done0`, `done1` output 1 each: one-cycle completion pulse to the winner.
- `gnt` output 1: index of the requester currently or last served.
- `busy` output 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, DRIVE, DONE. Settle counter is 8 bits. Round-robin pointer `last` is 1 bit.
- IDLE, no req: remain in IDLE. Adder inputs and result registers are held.
- IDLE, exactly one req: grant it.
- IDLE, both req: grant `!last`.
- On grant edge:
  - latch winner's a/b/cin into `add_a`/`add_b`/`add_cin`;
  - set `gnt` = winner and `last` = winner;
  - load counter with SETTLE-1;
  - go to DRIVE.
- DRIVE, counter != 0: decrement the counter; adder inputs are held.
- DRIVE, counter == 0:
  - capture `add_sum`/`add_cout` into `sum_out`/`cout_out`;
  - set `done[gnt]` = 1;
  - go to DONE.
- DONE: `done[gnt]` is high for exactly this cycle. Requests are ignored. Go unconditionally to IDLE.
- `done` of the non-granted requester is never asserted.
- A requester must drop req by the edge that ends its DONE cycle. Otherwise it is treated as a new request in the following IDLE cycle.
- Arithmetic is performed entirely by the external adder. The block never modifies operands. `cout_out` is the adder's carry-out of bit n-1.
- A req that drops while the block is in DRIVE or DONE has no effect: the operation in flight completes and reports done.
- A req that rises while busy waits. It is arbitrated in the next IDLE cycle.

## Timing
- Reset values:
  - state IDLE, counter 0, `last` = 1 (so requester 0 wins the first tie);
  - `add_a`, `add_b`, `add_cin`, `sum_out`, `cout_out`, `done0`, `done1`, `gnt`, `busy` all 0.
- Reset during DRIVE or DONE aborts the operation. No done pulse is issued and all outputs take their reset values on that edge.
- Reset has priority over every other transition.
- Latency: grant edge at cycle t; DRIVE spans cycles t+1..t+SETTLE; done is high in cycle t+SETTLE+1.
- Throughput: one operation per SETTLE+2 cycles under continuous requests.
- `busy` is high from cycle t+1 through the DONE cycle inclusive.
- SETTLE=1: DRIVE lasts exactly one cycle.
- `sum_out`/`cout_out` change only on capture edges.

## Test plan
- Reset: assert `rst` for 2 cycles with `req0`=1 → all outputs 0, no grant until the first cycle after `rst` falls.
- Single op, n=4, SETTLE=2: `req0`, a0=4'h7, b0=4'h9, cin0=0 → `add_a`=7 and `add_b`=9 from t+1, `done0` high in cycle t+3, `sum_out`=4'h0, `cout_out`=1, `done1` stays 0.
- Tie fairness: `req0` and `req1` held high continuously, a1=4'h3, b1=4'h4, cin1=1 → grant order 0,1,0,1, with done pulses 4 cycles apart. Every requester-1 result is `sum_out`=4'h8, `cout_out`=0.
- Late arrival: `req1` rises while requester 0's op is in DRIVE → requester 0 completes, and requester 1 is granted in the IDLE cycle right after DONE.
- Abort: `rst` pulsed in the second DRIVE cycle → no done pulse, `sum_out` = 0, and a fresh request then completes normally.
- SETTLE=1 and SETTLE=5: measure grant-to-done → 2 and 6 cycles respectively. Random operands must match a+b+cin.
